// File: rtl/bcd_down_timer_if.sv
// Bus between the tick/control source and the BCD down-timer.
// The master drives the control inputs and the preset; the slave (the
// timer) returns the count and status flags.
interface bcd_down_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  zero_pulse;

  modport master (
    output load, load_val, start, pause, tick,
    input  q, running, done, zero_pulse
  );

  modport slave (
    input  load, load_val, start, pause, tick,
    output q, running, done, zero_pulse
  );
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with a load/start/pause/expiry FSM.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | preset held, waiting for start (also after load/reset)
// S_RUN    | counting; one BCD decrement per cycle with tick high
// S_PAUSED | count frozen, start (without pause) resumes
// S_DONE   | count reached zero; only load or reset leaves
//
// Control priority per cycle: reset > load > pause > start > tick.
// All outputs are registers updated together with the state.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  bcd_down_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] q_r;
  logic                running_r;
  logic                done_r;
  logic                zero_pulse_r;

  logic [4*DIGITS-1:0] dec_q;
  logic [4*DIGITS-1:0] clamp_val;
  logic                q_is_zero;
  logic                dec_is_zero;

  // Single-cycle BCD decrement: the borrow ripples combinationally from
  // digit 0 upward and stops at the first non-zero digit.
  always_comb begin
    logic borrow;
    dec_q  = q_r;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (q_r[4*i +: 4] == 4'd0) begin
          dec_q[4*i +: 4] = 4'd9;
        end else begin
          dec_q[4*i +: 4] = q_r[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  // Preset digits outside 0..9 are stored as 9.
  always_comb begin
    clamp_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        clamp_val[4*i +: 4] = 4'd9;
      end else begin
        clamp_val[4*i +: 4] = bus.load_val[4*i +: 4];
      end
    end
  end

  assign q_is_zero   = (q_r == '0);
  assign dec_is_zero = (dec_q == '0);

  // Control FSM with registered count and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      q_r          <= '0;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      zero_pulse_r <= 1'b0;
    end else if (bus.load) begin
      state        <= S_IDLE;
      q_r          <= clamp_val;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      zero_pulse_r <= 1'b0;
    end else begin
      zero_pulse_r <= 1'b0;
      case (state)
        S_IDLE: begin
          // pause outranks start, so start is honoured only with pause low
          if (bus.start && !bus.pause) begin
            if (q_is_zero) begin
              state        <= S_DONE;
              done_r       <= 1'b1;
              zero_pulse_r <= 1'b1;
            end else begin
              state     <= S_RUN;
              running_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            state     <= S_PAUSED;
            running_r <= 1'b0;
          end else if (bus.tick && !q_is_zero) begin
            q_r <= dec_q;
            if (dec_is_zero) begin
              state        <= S_DONE;
              running_r    <= 1'b0;
              done_r       <= 1'b1;
              zero_pulse_r <= 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (bus.start && !bus.pause) begin
            state     <= S_RUN;
            running_r <= 1'b1;
          end
        end
        S_DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          running_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.running    = running_r;
  assign bus.done       = done_r;
  assign bus.zero_pulse = zero_pulse_r;

endmodule
